// File: rtl/kb_fifo_pkg.sv
// Shared types and key codes for the keyboard character FIFO.
// Optional KB_FIFO_COALESCE_EN is consumed by kb_char_fifo.
package kb_fifo_pkg;

  typedef enum logic {
    W_IDLE,
    W_ACK
  } wr_state_e;

  localparam logic [6:0] KEY_W = 7'h57;
  localparam logic [6:0] KEY_A = 7'h41;
  localparam logic [6:0] KEY_S = 7'h53;
  localparam logic [6:0] KEY_D = 7'h44;

endpackage

// File: rtl/kb_fifo_wr_handshake.sv
// Four-phase write handshake: one accept pulse per wr_en high period,
// ack held until the request drops.
module kb_fifo_wr_handshake
  import kb_fifo_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_wr_en,
  output logic o_wr_accept,
  output logic o_wr_ack
);

  wr_state_e r_state;
  wr_state_e w_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= W_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_wr_accept = 1'b0;
    o_wr_ack    = 1'b0;
    unique case (r_state)
      W_IDLE: begin
        if (i_wr_en) begin
          o_wr_accept = 1'b1;
          w_next      = W_ACK;
        end
      end
      W_ACK: begin
        o_wr_ack = 1'b1;
        if (!i_wr_en) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

endmodule

// File: rtl/kb_char_fifo.sv
// FWFT keyboard character FIFO; drops and flags overflow when full.
// Define KB_FIFO_COALESCE_EN to suppress repeats of the newest entry.
module kb_char_fifo
  import kb_fifo_pkg::*;
#(
  parameter int DATA_W     = 7,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  fifo_clk,
  input  logic                  fifo_rst,
  input  logic [DATA_W-1:0]     din,
  input  logic                  wr_en,
  output logic                  wr_ack,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                r_overflow;

  logic w_accept;
  logic w_rd_eff;
  logic w_dup;
  logic w_store;
  logic w_drop;

  kb_fifo_wr_handshake u_hs (
    .i_clk       (fifo_clk),
    .i_rst       (fifo_rst),
    .i_wr_en     (wr_en),
    .o_wr_accept (w_accept),
    .o_wr_ack    (wr_ack)
  );

  assign count    = r_wr_ptr - r_rd_ptr;
  assign empty    = (count == '0);
  assign full     = count[DEPTH_LOG2];
  assign overflow = r_overflow;
  assign dout     = empty ? '0 : r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

`ifdef KB_FIFO_COALESCE_EN
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;
  logic [DEPTH_LOG2-1:0] w_last_idx;
  assign w_last_idx = r_wr_ptr[DEPTH_LOG2-1:0] - IDX_ONE;
  assign w_dup      = !empty && (din == r_mem[w_last_idx]);
`else
  assign w_dup = 1'b0;
`endif

  // A full FIFO still stores when the head leaves on the same edge
  assign w_rd_eff = rd_en && !empty;
  assign w_store  = w_accept && !w_dup && (!full || w_rd_eff);
  assign w_drop   = w_accept && !w_dup && full && !w_rd_eff;

  always_ff @(posedge fifo_clk) begin
    if (fifo_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_store)  r_wr_ptr   <= r_wr_ptr + PTR_ONE;
      if (w_rd_eff) r_rd_ptr   <= r_rd_ptr + PTR_ONE;
      if (w_drop)   r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge fifo_clk) begin
    if (w_store) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: tb/tb_kb_char_fifo.sv
// Directed self-checking bench for kb_char_fifo.
// Inputs change and outputs are sampled on the falling edge.
module tb_kb_char_fifo;

  logic       fifo_clk;
  logic       fifo_rst;
  logic [6:0] din;
  logic       wr_en;
  logic       wr_ack;
  logic       rd_en;
  logic [6:0] dout;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  kb_char_fifo #(.DATA_W(7), .DEPTH_LOG2(3)) dut (
    .fifo_clk (fifo_clk),
    .fifo_rst (fifo_rst),
    .din      (din),
    .wr_en    (wr_en),
    .wr_ack   (wr_ack),
    .rd_en    (rd_en),
    .dout     (dout),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  initial fifo_clk = 1'b0;
  always #5 fifo_clk = ~fifo_clk;

  task automatic do_reset();
    fifo_rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din = '0;
    repeat (2) @(negedge fifo_clk);
    fifo_rst = 1'b0;
    @(negedge fifo_clk);
  endtask

  task automatic write_one(input logic [6:0] v);
    din = v;
    wr_en = 1'b1;
    @(negedge fifo_clk);
    wr_en = 1'b0;
    @(negedge fifo_clk);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge fifo_clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({wr_ack, empty, full, count, overflow, dout} !== {1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 7'd0}) begin
      errors++;
      $display("FAIL reset: ack=%b empty=%b full=%b count=%0d ovf=%b dout=%h",
               wr_ack, empty, full, count, overflow, dout);
    end
  endtask

  task automatic test_single();
    do_reset();
    din = 7'h57;
    wr_en = 1'b1;
    @(negedge fifo_clk);
    checks++;
    if ({wr_ack, empty, count, dout} !== {1'b1, 1'b0, 4'd1, 7'h57}) begin
      errors++;
      $display("FAIL single_write: ack=%b empty=%b count=%0d dout=%h want 1 0 1 57",
               wr_ack, empty, count, dout);
    end
    wr_en = 1'b0;
    @(negedge fifo_clk);
    checks++;
    if (wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL single_ack_release: ack=%b want 0", wr_ack);
    end
    pop_one();
    checks++;
    if ({empty, dout, count} !== {1'b1, 7'h00, 4'd0}) begin
      errors++;
      $display("FAIL single_pop: empty=%b dout=%h count=%0d want 1 00 0",
               empty, dout, count);
    end
  endtask

  task automatic test_hold();
    do_reset();
    din = 7'h41;
    wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge fifo_clk);
      checks++;
      if ({wr_ack, count} !== {1'b1, 4'd1}) begin
        errors++;
        $display("FAIL hold_cycle%0d: ack=%b count=%0d want 1 1", i, wr_ack, count);
      end
    end
    wr_en = 1'b0;
    @(negedge fifo_clk);
    checks++;
    if ({wr_ack, count, dout} !== {1'b0, 4'd1, 7'h41}) begin
      errors++;
      $display("FAIL hold_release: ack=%b count=%0d dout=%h want 0 1 41",
               wr_ack, count, dout);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) write_one(7'(8'h41 + i));
    checks++;
    if ({full, count, overflow} !== {1'b1, 4'd8, 1'b0}) begin
      errors++;
      $display("FAIL fill8: full=%b count=%0d ovf=%b want 1 8 0", full, count, overflow);
    end
    din = 7'h49;
    wr_en = 1'b1;
    @(negedge fifo_clk);
    checks++;
    if ({wr_ack, full, count, overflow} !== {1'b1, 1'b1, 4'd8, 1'b1}) begin
      errors++;
      $display("FAIL ninth_write: ack=%b full=%b count=%0d ovf=%b want 1 1 8 1",
               wr_ack, full, count, overflow);
    end
    wr_en = 1'b0;
    @(negedge fifo_clk);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dout !== 7'(8'h41 + i)) begin
        errors++;
        $display("FAIL drain%0d: dout=%h want %h", i, dout, 7'(8'h41 + i));
      end
      pop_one();
    end
    checks++;
    if ({empty, overflow} !== {1'b1, 1'b1}) begin
      errors++;
      $display("FAIL drained: empty=%b ovf=%b want 1 1 (sticky)", empty, overflow);
    end
  endtask

  task automatic test_full_rw();
    logic [6:0] exp [8];
    do_reset();
    for (int i = 0; i < 8; i++) write_one(7'(8'h41 + i));
    din = 7'h50;
    wr_en = 1'b1;
    rd_en = 1'b1;
    @(negedge fifo_clk);
    rd_en = 1'b0;
    checks++;
    if ({count, overflow, full, dout} !== {4'd8, 1'b0, 1'b1, 7'h42}) begin
      errors++;
      $display("FAIL full_rw: count=%0d ovf=%b full=%b dout=%h want 8 0 1 42",
               count, overflow, full, dout);
    end
    wr_en = 1'b0;
    @(negedge fifo_clk);
    for (int i = 0; i < 7; i++) exp[i] = 7'(8'h42 + i);
    exp[7] = 7'h50;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dout !== exp[i]) begin
        errors++;
        $display("FAIL full_rw_drain%0d: dout=%h want %h", i, dout, exp[i]);
      end
      pop_one();
    end
  endtask

  task automatic test_empty_rd_write();
    do_reset();
    din = 7'h53;
    wr_en = 1'b1;
    rd_en = 1'b1;
    @(negedge fifo_clk);
    rd_en = 1'b0;
    wr_en = 1'b0;
    checks++;
    if ({count, dout} !== {4'd1, 7'h53}) begin
      errors++;
      $display("FAIL empty_rd_write: count=%0d dout=%h want 1 53", count, dout);
    end
    @(negedge fifo_clk);
  endtask

  task automatic test_wrap();
    logic [6:0] v;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      v = 7'(8'h10 + i);
      write_one(v);
      checks++;
      if ({count, dout} !== {4'd1, v}) begin
        errors++;
        $display("FAIL wrap%0d: count=%0d dout=%h want 1 %h", i, count, dout, v);
      end
      pop_one();
      checks++;
      if (count !== 4'd0) begin
        errors++;
        $display("FAIL wrap_pop%0d: count=%0d want 0", i, count);
      end
    end
  endtask

  task automatic test_coalesce();
`ifdef KB_FIFO_COALESCE_EN
    logic [6:0] exp [3] = '{7'h41, 7'h44, 7'h00};
    logic [3:0] n = 4'd2;
`else
    logic [6:0] exp [3] = '{7'h41, 7'h41, 7'h44};
    logic [3:0] n = 4'd3;
`endif
    do_reset();
    write_one(7'h41);
    write_one(7'h41);
    write_one(7'h44);
    checks++;
    if ({count, overflow} !== {n, 1'b0}) begin
      errors++;
      $display("FAIL coalesce_count: count=%0d ovf=%b want %0d 0", count, overflow, n);
    end
    for (int i = 0; i < 3; i++) begin
      if (i < int'(n)) begin
        checks++;
        if (dout !== exp[i]) begin
          errors++;
          $display("FAIL coalesce_order%0d: dout=%h want %h", i, dout, exp[i]);
        end
        pop_one();
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL coalesce_empty: empty=%b want 1", empty);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    din = 7'h44;
    wr_en = 1'b1;
    @(negedge fifo_clk);
    fifo_rst = 1'b1;
    @(negedge fifo_clk);
    checks++;
    if ({wr_ack, count} !== {1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset_mid: ack=%b count=%0d want 0 0", wr_ack, count);
    end
    fifo_rst = 1'b0;
    @(negedge fifo_clk);
    checks++;
    if ({wr_ack, count, dout} !== {1'b1, 4'd1, 7'h44}) begin
      errors++;
      $display("FAIL reset_rerequest: ack=%b count=%0d dout=%h want 1 1 44",
               wr_ack, count, dout);
    end
    wr_en = 1'b0;
    @(negedge fifo_clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_overflow();
    test_full_rw();
    test_empty_rd_write();
    test_wrap();
    test_coalesce();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
